// File: rtl/router_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 1x3 router output-side controller:
//   - header address width and port address codes (2'b11 is the drop code)
//   - timer FSM state encoding used by sync_timeout_timer
//   - default timeout settings and drop-counter width
// Optional feature macro: SYNC_DROP_CNT_EN (per-port drop counters).
// ----------------------------------------------------------------------------
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;

    localparam logic [ADDR_W-1:0] ADDR_PORT0   = 2'b00;
    localparam logic [ADDR_W-1:0] ADDR_PORT1   = 2'b01;
    localparam logic [ADDR_W-1:0] ADDR_PORT2   = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    // Consecutive valid-but-unread cycles before a port is flushed.
    localparam int TIMEOUT_DEFAULT = 30;
    localparam int CNT_W_DEFAULT   = 5;

    localparam int DROP_W = 8;

    typedef enum logic [1:0] {
        T_IDLE  = 2'b00,
        T_COUNT = 2'b01,
        T_FLUSH = 2'b10
    } timer_state_e;

endpackage

// File: rtl/sync_timeout_timer.sv
// ----------------------------------------------------------------------------
// sync_timeout_timer
// One port's stall timer. Counts consecutive cycles where the port holds data
// that nobody reads; on the TIMEOUT-th such cycle it raises a one-cycle
// registered soft_reset pulse that flushes the FIFO and releases the FSM.
//
// Ports:
//   clk          in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   vld_i        in   port holds data (~empty)
//   read_en_i    in   downstream read strobe
//   soft_reset_o out  one-cycle flush pulse
//   drop_cnt_o   out  saturating flush count (only with SYNC_DROP_CNT_EN)
//
// Optional feature macro: SYNC_DROP_CNT_EN.
// ----------------------------------------------------------------------------
module sync_timeout_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              vld_i,
    input  logic              read_en_i,
    output logic              soft_reset_o
`ifdef SYNC_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt_o
`endif
);

    // The counter must reach TIMEOUT-1 without wrapping.
    if ((2 ** CNT_W) <= TIMEOUT) begin : g_cnt_w_check
        $error("sync_timeout_timer: CNT_W=%0d too narrow for TIMEOUT=%0d", CNT_W, TIMEOUT);
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    timer_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             soft_reset_q;
    logic             stall;

    assign stall = vld_i & ~read_en_i;

    // NOTE: every signal written here gets its default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            T_IDLE: begin
                cnt_d = '0;
                if (stall) begin
                    state_d = T_COUNT;
                    cnt_d   = CNT_ONE;
                end
            end
            T_COUNT: begin
                if (!stall) begin
                    state_d = T_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = T_FLUSH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // The FIFO is still non-empty during the flush cycle; ignoring
            // inputs here is what prevents a back-to-back second pulse.
            T_FLUSH: begin
                state_d = T_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = T_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= T_IDLE;
            cnt_q        <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            soft_reset_q <= (state_d == T_FLUSH);
        end
    end

    assign soft_reset_o = soft_reset_q;

`ifdef SYNC_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt_q <= '0;
        end else if ((state_d == T_FLUSH) && (state_q != T_FLUSH) && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_W'(1);
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: rtl/router_sync_ctrl.sv
// ----------------------------------------------------------------------------
// router_sync_ctrl
// Output-side controller of the 1x3 router. Latches the packet destination at
// header decode, steers the FSM write strobe to one FIFO, returns that FIFO's
// full flag, drives per-port valid, and flushes stalled ports via per-port
// timeout timers.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   detect_add, data_in      load destination address (3 = drop packet)
//   write_en_reg             FSM write request
//   read_en_0..2             downstream read strobes
//   empty_0..2, full_0..2    FIFO status
//   fifo_full                full flag of the addressed FIFO (0 when dropping)
//   write_en[2:0]            one-hot FIFO write enable
//   vld_out_0..2             ~empty per port
//   soft_reset_0..2          one-cycle flush pulse per port
//   drop_cnt_0..2            flush counters (only with SYNC_DROP_CNT_EN)
//
// Optional feature macro: SYNC_DROP_CNT_EN.
// ----------------------------------------------------------------------------
module router_sync_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_en_reg,
    input  logic              read_en_0,
    input  logic              read_en_1,
    input  logic              read_en_2,
    input  logic              empty_0,
    input  logic              empty_1,
    input  logic              empty_2,
    input  logic              full_0,
    input  logic              full_1,
    input  logic              full_2,
    output logic              fifo_full,
    output logic [2:0]        write_en,
    output logic              vld_out_0,
    output logic              vld_out_1,
    output logic              vld_out_2,
    output logic              soft_reset_0,
    output logic              soft_reset_1,
    output logic              soft_reset_2
`ifdef SYNC_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt_0,
    output logic [DROP_W-1:0] drop_cnt_1,
    output logic [DROP_W-1:0] drop_cnt_2
`endif
);

    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [NUM_PORTS-1:0] vld;
    logic [NUM_PORTS-1:0] rd;
    logic [NUM_PORTS-1:0] soft_reset;

    // ---------------------------------------------------------------- address
    assign addr_d = detect_add ? data_in : addr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q <= ADDR_PORT0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // ------------------------------------------------- write steer / full mux
    // Decode from the registered address, so a write in the detect_add cycle
    // still targets the previous packet's FIFO.
    always_comb begin
        write_en  = 3'b000;
        fifo_full = 1'b0;
        case (addr_q)
            ADDR_PORT0: begin
                write_en  = {2'b00, write_en_reg};
                fifo_full = full_0;
            end
            ADDR_PORT1: begin
                write_en  = {1'b0, write_en_reg, 1'b0};
                fifo_full = full_1;
            end
            ADDR_PORT2: begin
                write_en  = {write_en_reg, 2'b00};
                fifo_full = full_2;
            end
            // Invalid destination: the packet is dropped, and reporting
            // not-full keeps the FSM streaming it out.
            ADDR_INVALID: begin
                write_en  = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    // ----------------------------------------------------------- valid/timers
    assign vld = ~{empty_2, empty_1, empty_0};
    assign rd  = {read_en_2, read_en_1, read_en_0};

    assign vld_out_0 = vld[0];
    assign vld_out_1 = vld[1];
    assign vld_out_2 = vld[2];

`ifdef SYNC_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt [NUM_PORTS];
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_timer
        sync_timeout_timer #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_timer (
            .clk          (clk),
            .resetn       (resetn),
            .vld_i        (vld[p]),
            .read_en_i    (rd[p]),
            .soft_reset_o (soft_reset[p])
`ifdef SYNC_DROP_CNT_EN
            ,
            .drop_cnt_o   (drop_cnt[p])
`endif
        );
    end

    assign soft_reset_0 = soft_reset[0];
    assign soft_reset_1 = soft_reset[1];
    assign soft_reset_2 = soft_reset[2];

`ifdef SYNC_DROP_CNT_EN
    assign drop_cnt_0 = drop_cnt[0];
    assign drop_cnt_1 = drop_cnt[1];
    assign drop_cnt_2 = drop_cnt[2];
`endif

endmodule

// File: tb/tb_router_sync_ctrl.sv
// ----------------------------------------------------------------------------
// tb_router_sync_ctrl
// Scoreboard bench for router_sync_ctrl. Each cycle a behavioural model
// (run-length of valid-unread cycles per port) pushes the expected outputs;
// the sample point pops and compares them against the DUT.
// Optional feature macro: SYNC_DROP_CNT_EN enables the drop-counter tests.
// ----------------------------------------------------------------------------
module tb_router_sync_ctrl;

    localparam int TO = 30;

    typedef struct packed {
        logic [2:0]  we;
        logic        ff;
        logic [2:0]  vld;
        logic [2:0]  sr;
        logic [23:0] drop;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_en_reg;
    logic [2:0] rd, emp, fl;
    logic       fifo_full;
    logic [2:0] write_en;
    logic [2:0] vld_o, sr_o;
`ifdef SYNC_DROP_CNT_EN
    logic [7:0] drop_0, drop_1, drop_2;
`endif

    always #5 clk = ~clk;

    router_sync_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .detect_add   (detect_add),
        .data_in      (data_in),
        .write_en_reg (write_en_reg),
        .read_en_0    (rd[0]),
        .read_en_1    (rd[1]),
        .read_en_2    (rd[2]),
        .empty_0      (emp[0]),
        .empty_1      (emp[1]),
        .empty_2      (emp[2]),
        .full_0       (fl[0]),
        .full_1       (fl[1]),
        .full_2       (fl[2]),
        .fifo_full    (fifo_full),
        .write_en     (write_en),
        .vld_out_0    (vld_o[0]),
        .vld_out_1    (vld_o[1]),
        .vld_out_2    (vld_o[2]),
        .soft_reset_0 (sr_o[0]),
        .soft_reset_1 (sr_o[1]),
        .soft_reset_2 (sr_o[2])
`ifdef SYNC_DROP_CNT_EN
        ,
        .drop_cnt_0   (drop_0),
        .drop_cnt_1   (drop_1),
        .drop_cnt_2   (drop_2)
`endif
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    // Model state
    logic [1:0] m_addr;
    int         m_run  [3];
    logic [2:0] m_soft;
    int         m_drop [3];

    // Observation bookkeeping for directed checks
    logic [2:0] obs_sr;
    int         first_sr [3];
    int         pulses   [3];
    int         cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_clear();
        m_addr = 2'b00;
        m_soft = 3'b000;
        for (int p = 0; p < 3; p++) begin
            m_run[p]  = 0;
            m_drop[p] = 0;
        end
    endtask

    task automatic obs_clear();
        cyc = 0;
        for (int p = 0; p < 3; p++) begin
            first_sr[p] = 0;
            pulses[p]   = 0;
        end
    endtask

    // Called just after a negedge with inputs already driven; returns at the
    // following negedge.
    task automatic step();
        exp_t e;
        exp_t x;
        #1;
        e.we   = (m_addr == 2'd3) ? 3'b000 : (3'(write_en_reg) << m_addr);
        e.ff   = (m_addr == 2'd3) ? 1'b0 : fl[m_addr];
        e.vld  = ~emp;
        e.sr   = m_soft;
        e.drop = {8'(m_drop[2]), 8'(m_drop[1]), 8'(m_drop[0])};
        sb.push_back(e);

        x = sb.pop_front();
        check("write_en",  32'(write_en),  32'(x.we));
        check("fifo_full", 32'(fifo_full), 32'(x.ff));
        check("vld_out",   32'(vld_o),     32'(x.vld));
        check("soft_rst",  32'(sr_o),      32'(x.sr));
`ifdef SYNC_DROP_CNT_EN
        check("drop_cnt",  32'({drop_2, drop_1, drop_0}), 32'(x.drop));
`endif
        cyc++;
        obs_sr = sr_o;
        for (int p = 0; p < 3; p++) begin
            if (sr_o[p]) begin
                pulses[p]++;
                if (first_sr[p] == 0) first_sr[p] = cyc;
            end
        end

        @(posedge clk);
        if (!resetn) begin
            model_clear();
        end else begin
            if (detect_add) m_addr = data_in;
            for (int p = 0; p < 3; p++) begin
                if (m_soft[p]) begin
                    m_soft[p] = 1'b0;
                    m_run[p]  = 0;
                end else if (!emp[p] && !rd[p]) begin
                    m_run[p]++;
                    if (m_run[p] == TO) begin
                        m_soft[p] = 1'b1;
                        m_run[p]  = 0;
                        if (m_drop[p] != 255) m_drop[p]++;
                    end
                end else begin
                    m_run[p] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_clear();
        step();
        resetn = 1'b1;
        obs_clear();
    endtask

    task automatic idle_inputs();
        detect_add   = 1'b0;
        data_in      = 2'b00;
        write_en_reg = 1'b0;
        rd           = 3'b000;
        emp          = 3'b111;
        fl           = 3'b000;
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        model_clear();
        obs_clear();
        @(negedge clk);
        do_reset();

        // 1: address 2 steering and full mux
        detect_add = 1'b1; data_in = 2'd2; write_en_reg = 1'b1; step();
        detect_add = 1'b0; step();
        fl = 3'b100; step();
        check("t1_we", 32'(write_en), 32'(3'b100));
        check("t1_ff", 32'(fifo_full), 32'(1'b1));
        fl = 3'b011; step();

        // 2: invalid address drops the packet
        detect_add = 1'b1; data_in = 2'd3; step();
        detect_add = 1'b0; fl = 3'b111; step();
        check("t2_we", 32'(write_en), 32'(3'b000));
        check("t2_ff", 32'(fifo_full), 32'(1'b0));
        detect_add = 1'b1; data_in = 2'd1; step();
        detect_add = 1'b0; step();
        idle_inputs();

        // 3: port 1 timeout
        do_reset();
        emp = 3'b101;
        for (int i = 0; i < 40; i++) step();
        check("t3_first", 32'(first_sr[1]), 32'd31);
        check("t3_pulses", 32'(pulses[1]), 32'd1);
        check("t3_others", 32'(pulses[0] + pulses[2]), 32'd0);

        // 4: read on cycle 29 restarts the count
        do_reset();
        emp = 3'b110;
        for (int i = 1; i <= 65; i++) begin
            rd[0] = (i == 29);
            step();
        end
        rd = 3'b000;
        check("t4_first", 32'(first_sr[0]), 32'd60);

        // 5: reset mid-count on port 2
        do_reset();
        emp = 3'b011;
        for (int i = 0; i < 20; i++) step();
        check("t5_pre", 32'(pulses[2]), 32'd0);
        do_reset();
        for (int i = 0; i < 35; i++) step();
        check("t5_first", 32'(first_sr[2]), 32'd31);

        // simultaneous flush on all ports
        do_reset();
        emp = 3'b000;
        for (int i = 0; i < 31; i++) step();
        check("all_sr", 32'(obs_sr), 32'(3'b111));
        idle_inputs();

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            detect_add   = ($urandom_range(0, 7) == 0);
            data_in      = 2'($urandom_range(0, 3));
            write_en_reg = 1'($urandom_range(0, 1));
            fl           = 3'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) begin
                emp[p] = ($urandom_range(0, 15) == 0);
                rd[p]  = ($urandom_range(0, 39) == 0);
            end
            step();
        end
        idle_inputs();

`ifdef SYNC_DROP_CNT_EN
        // 6: drop counter counts and saturates
        do_reset();
        emp = 3'b110;
        for (int i = 0; i < 3 * (TO + 1); i++) step();
        check("t6_drop3", 32'(drop_0), 32'd3);
        for (int i = 0; i < 297 * (TO + 1); i++) step();
        check("t6_sat", 32'(drop_0), 32'd255);
        idle_inputs();
`endif

        // final reset-state check
        do_reset();
        check("rst_ff", 32'(fifo_full), 32'(1'b0));
        check("rst_sr", 32'(sr_o), 32'(3'b000));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
